fifo_sync: RTL

- Single-clock, parametrised-depth synchronous FIFO with first-word-fall-through output.
- Generalises the one-entry buffer to N entries.
- Adds simultaneous push/pull, fill level, programmable almost-full/almost-empty thresholds and overflow/underflow error pulses.
- Sits between the AXI slave front-end and the SPI shift engine as TX and RX data buffering.

---
 rtl/fifo_sync_pkg.sv | 19 +
 rtl/fifo_sync_if.sv | 40 ++++
 rtl/fifo_sync_ram.sv | 33 +++
 rtl/fifo_sync.sv | 115 +++++++++++
 4 files changed

// File: rtl/fifo_sync_pkg.sv
// rtl/fifo_sync_pkg.sv - shared constants/helpers for the fifo_sync slice
// Purpose: provides clog2 used to size pointers and the level counter.
// Ports: none (package).
package fifo_sync_pkg;

    // Bits needed to index 'value' entries; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// rtl/fifo_sync_if.sv - push/pull data and status bundle for fifo_sync
// Purpose: groups the FIFO data path and status flags.
// Ports (named from the FIFO's point of view):
//   data_i/push_i/pull_i  - write data, write request, read request
//   data_o                - head-of-queue word (first-word-fall-through)
//   full_o/empty_o/afull_o/aempty_o/level_o - registered fill status
//   ovf_o/unf_o           - one-cycle rejected push / rejected pull pulses
// Modports: slave = FIFO side, master = producer/consumer side.
interface fifo_sync_if
    import fifo_sync_pkg::*;
#(
    parameter int g_width = 32,
    parameter int g_depth = 8
) ();

    localparam int LW = clog2(g_depth) + 1;

    logic [g_width-1:0] data_i;
    logic               push_i;
    logic               pull_i;
    logic [g_width-1:0] data_o;
    logic               full_o;
    logic               empty_o;
    logic               afull_o;
    logic               aempty_o;
    logic [LW-1:0]      level_o;
    logic               ovf_o;
    logic               unf_o;

    modport slave (
        input  data_i, push_i, pull_i,
        output data_o, full_o, empty_o, afull_o, aempty_o, level_o, ovf_o, unf_o
    );

    modport master (
        output data_i, push_i, pull_i,
        input  data_o, full_o, empty_o, afull_o, aempty_o, level_o, ovf_o, unf_o
    );

endinterface

// File: rtl/fifo_sync_ram.sv
// rtl/fifo_sync_ram.sv - storage array for fifo_sync
// Purpose: simple dual-port memory, synchronous write, asynchronous read.
// Ports:
//   clk_i   - clock, rising edge
//   we_i    - write enable
//   waddr_i - write address, wdata_i - write data
//   raddr_i - read address,  rdata_o - read data (combinational)
// Contents are deliberately not reset.
module fifo_sync_ram
    import fifo_sync_pkg::*;
#(
    parameter int g_width = 32,
    parameter int g_depth = 8
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [clog2(g_depth)-1:0]  waddr_i,
    input  logic [g_width-1:0]         wdata_i,
    input  logic [clog2(g_depth)-1:0]  raddr_i,
    output logic [g_width-1:0]         rdata_o
);

    logic [g_width-1:0] mem_q [g_depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock first-word-fall-through FIFO
// Purpose: N-entry data buffer with fill level, almost-full/almost-empty
//          thresholds and overflow/underflow pulses.
// Ports:
//   clk_i - clock, rising edge
//   rst_i - asynchronous reset, active-low
//   bus   - fifo_sync_if.slave (data, push/pull, status, error pulses)
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int g_width  = 32,
    parameter int g_depth  = 8,
    parameter int g_afull  = 6,
    parameter int g_aempty = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fifo_sync_if.slave   bus
);

    localparam int AW = clog2(g_depth);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] LVL_FULL   = LW'(g_depth);
    localparam logic [LW-1:0] LVL_AFULL  = LW'(g_afull);
    localparam logic [LW-1:0] LVL_AEMPTY = LW'(g_aempty);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          push_ok, pull_ok;

    // Acceptance uses the registered (pre-edge) flags, so a full FIFO
    // never refills in the same cycle and an empty one never passes through.
    assign push_ok = bus.push_i & ~full_q;
    assign pull_ok = bus.pull_i & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pull_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push_ok, pull_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Flags follow the next level so they move on the same edge as it.
        full_d   = (level_d == LVL_FULL);
        empty_d  = (level_d == '0);
        afull_d  = (level_d >= LVL_AFULL);
        aempty_d = (level_d <= LVL_AEMPTY);
        ovf_d    = bus.push_i & full_q;
        unf_d    = bus.pull_i & empty_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_sync_ram #(
        .g_width (g_width),
        .g_depth (g_depth)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (bus.data_o)
    );

    assign bus.full_o   = full_q;
    assign bus.empty_o  = empty_q;
    assign bus.afull_o  = afull_q;
    assign bus.aempty_o = aempty_q;
    assign bus.level_o  = level_q;
    assign bus.ovf_o    = ovf_q;
    assign bus.unf_o    = unf_q;

endmodule
